// File: rtl/taxi_eth_lfc_ctrl.sv
// PAUSE (XON/XOFF) scheduler for the MAC: watermark hysteresis, minimum XOFF hold, periodic resend.
// Optional statistics counters are built when TAXI_LFC_CTRL_STATS_EN is defined.
module taxi_eth_lfc_ctrl #(
    parameter int FILL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [FILL_W-1:0] fill_level,
    input  logic [FILL_W-1:0] cfg_high_wm,
    input  logic [FILL_W-1:0] cfg_low_wm,
    input  logic [CNT_W-1:0]  cfg_refresh,
    input  logic [CNT_W-1:0]  cfg_hold,
    output logic              tx_lfc_req,
    output logic              tx_lfc_resend,
    output logic              xoff_active,
    output logic              cfg_err,
    input  logic              rx_lfc_req,
    output logic              rx_lfc_ack,
    output logic [CNT_W-1:0]  stat_xoff_events,
    output logic [CNT_W-1:0]  stat_rx_paused_cycles
);

    typedef enum logic {
        ST_XON  = 1'b0,
        ST_XOFF = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hold_tmr_reg, hold_tmr_next;
    logic [CNT_W-1:0] refresh_tmr_reg, refresh_tmr_next;
    logic             resend_reg, resend_next;
    logic             cfg_err_reg;
    logic             ack_reg;

    always_comb begin
        state_next       = state_reg;
        hold_tmr_next    = hold_tmr_reg;
        refresh_tmr_next = refresh_tmr_reg;
        resend_next      = 1'b0;
        case (state_reg)
            ST_XON: begin
                if (enable && !cfg_err_reg && (fill_level >= cfg_high_wm)) begin
                    state_next       = ST_XOFF;
                    hold_tmr_next    = cfg_hold;
                    refresh_tmr_next = cfg_refresh;
                end
            end
            ST_XOFF: begin
                // Loss of enable or a bad config bypasses the hold timer.
                if (((fill_level <= cfg_low_wm) && (hold_tmr_reg == '0)) || !enable || cfg_err_reg) begin
                    state_next = ST_XON;
                end else begin
                    if (hold_tmr_reg != '0) begin
                        hold_tmr_next = hold_tmr_reg - CNT_ONE;
                    end
                    if ((refresh_tmr_reg == CNT_ONE) && (cfg_refresh != '0)) begin
                        resend_next      = 1'b1;
                        refresh_tmr_next = cfg_refresh;
                    end else if (refresh_tmr_reg != '0) begin
                        refresh_tmr_next = refresh_tmr_reg - CNT_ONE;
                    end
                end
            end
            default: state_next = ST_XON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_XON;
            hold_tmr_reg    <= '0;
            refresh_tmr_reg <= '0;
            resend_reg      <= 1'b0;
            cfg_err_reg     <= 1'b0;
            ack_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_tmr_reg    <= hold_tmr_next;
            refresh_tmr_reg <= refresh_tmr_next;
            resend_reg      <= resend_next;
            cfg_err_reg     <= (cfg_low_wm >= cfg_high_wm);
            ack_reg         <= rx_lfc_req;
        end
    end

    assign tx_lfc_req    = (state_reg == ST_XOFF);
    assign xoff_active   = (state_reg == ST_XOFF);
    assign tx_lfc_resend = resend_reg;
    assign cfg_err       = cfg_err_reg;
    assign rx_lfc_ack    = ack_reg;

`ifdef TAXI_LFC_CTRL_STATS_EN
    logic [CNT_W-1:0] xoff_events_reg;
    logic [CNT_W-1:0] paused_cycles_reg;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xoff_events_reg   <= '0;
            paused_cycles_reg <= '0;
        end else begin
            if ((state_reg == ST_XON) && (state_next == ST_XOFF) && (xoff_events_reg != '1)) begin
                xoff_events_reg <= xoff_events_reg + CNT_ONE;
            end
            if (rx_lfc_req && ack_reg && (paused_cycles_reg != '1)) begin
                paused_cycles_reg <= paused_cycles_reg + CNT_ONE;
            end
        end
    end

    assign stat_xoff_events      = xoff_events_reg;
    assign stat_rx_paused_cycles = paused_cycles_reg;
`else
    assign stat_xoff_events      = '0;
    assign stat_rx_paused_cycles = '0;
`endif

endmodule
